// File: rtl/matrix_tile_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : matrix_tile_sequencer
// Purpose  : Address/control sequencer for the matrix-multiply core array.
//            Walks a size_row x size_column operand space in groups of
//            CORE_COUNT output columns (column fastest, then row, then group),
//            drives per-beat addresses, core enable mask and accumulator
//            clear, honours back-pressure, and emits a delayed tagged
//            write-back strobe for every completed dot product.
// Ports    : CLOCK_25, rst (async, active-high)
//            start, size_column, size_row        - job request / dimensions
//            in_ready                            - fetch path accepts beat
//            o_valid, o_column_adr, o_row_adr,
//            o_core_base, o_core_mask,
//            o_acc_clr, o_last                   - beat outputs
//            o_wb_valid, o_wb_row, o_wb_core_base - write-back strobe + tags
//            o_busy, o_done, o_err, o_state      - status
//            o_busy_cycles, o_stall_cycles       - performance counters
// Options  : MATRIX_SEQ_PERF_EN enables the performance counters; when it is
//            undefined both counter outputs are tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module matrix_tile_sequencer #(
   parameter int CORE_COUNT = 4,
   parameter int ADR_W      = 5,
   parameter int SIZE_W     = 8,
   parameter int PIPE_DEPTH = 2
) (
   input  logic                  CLOCK_25,
   input  logic                  rst,
   input  logic                  start,
   input  logic [SIZE_W-1:0]     size_column,
   input  logic [SIZE_W-1:0]     size_row,
   input  logic                  in_ready,
   output logic                  o_valid,
   output logic [ADR_W-1:0]      o_column_adr,
   output logic [ADR_W-1:0]      o_row_adr,
   output logic [ADR_W-1:0]      o_core_base,
   output logic [CORE_COUNT-1:0] o_core_mask,
   output logic                  o_acc_clr,
   output logic                  o_last,
   output logic                  o_wb_valid,
   output logic [ADR_W-1:0]      o_wb_row,
   output logic [ADR_W-1:0]      o_wb_core_base,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_err,
   output logic [2:0]            o_state,
   output logic [31:0]           o_busy_cycles,
   output logic [31:0]           o_stall_cycles
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_RUN   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // One extra bit so base+CORE_COUNT never wraps in the group/mask compares.
   localparam int EXT_W = SIZE_W + 1;
   localparam logic [EXT_W-1:0] ADR_SPAN  = EXT_W'(2 ** ADR_W);
   localparam logic [EXT_W-1:0] CORE_STEP = EXT_W'(CORE_COUNT);

   state_t            state_q, state_d;
   logic [SIZE_W-1:0] size_col_q, size_col_d;
   logic [SIZE_W-1:0] size_row_q, size_row_d;
   logic [ADR_W-1:0]  col_q, col_d;
   logic [ADR_W-1:0]  row_q, row_d;
   logic [ADR_W-1:0]  base_q, base_d;
   logic              err_q, err_d;

   logic [PIPE_DEPTH-1:0] wb_vld_q, wb_vld_d;
   logic [ADR_W-1:0]      wb_row_q  [PIPE_DEPTH];
   logic [ADR_W-1:0]      wb_row_d  [PIPE_DEPTH];
   logic [ADR_W-1:0]      wb_base_q [PIPE_DEPTH];
   logic [ADR_W-1:0]      wb_base_d [PIPE_DEPTH];

   logic             run;
   logic             accept;
   logic             col_end, row_end, grp_end;
   logic             size_bad;
   logic [EXT_W-1:0] col_ext, row_ext, base_ext, scol_ext, srow_ext;

   assign run      = (state_q == ST_RUN);
   assign accept   = run & in_ready;
   assign col_ext  = EXT_W'(col_q);
   assign row_ext  = EXT_W'(row_q);
   assign base_ext = EXT_W'(base_q);
   assign scol_ext = EXT_W'(size_col_q);
   assign srow_ext = EXT_W'(size_row_q);
   assign col_end  = (col_ext == scol_ext - EXT_W'(1));
   assign row_end  = (row_ext == srow_ext - EXT_W'(1));
   assign grp_end  = ((base_ext + CORE_STEP) >= scol_ext);
   assign size_bad = (size_col_q == '0) || (size_row_q == '0) ||
                     (scol_ext > ADR_SPAN) || (srow_ext > ADR_SPAN);

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge CLOCK_25 or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         size_col_q <= '0;
         size_row_q <= '0;
         col_q      <= '0;
         row_q      <= '0;
         base_q     <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         size_col_q <= size_col_d;
         size_row_q <= size_row_d;
         col_q      <= col_d;
         row_q      <= row_d;
         base_q     <= base_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      size_col_d = size_col_q;
      size_row_d = size_row_q;
      col_d      = col_q;
      row_d      = row_q;
      base_d     = base_q;
      err_d      = err_q;
      case (state_q)
         ST_IDLE: begin
            col_d  = '0;
            row_d  = '0;
            base_d = '0;
            if (start) begin
               size_col_d = size_column;
               size_row_d = size_row;
               state_d    = ST_LOAD;
            end
         end
         ST_LOAD: begin
            col_d  = '0;
            row_d  = '0;
            base_d = '0;
            if (size_bad) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end else begin
               err_d   = 1'b0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (accept) begin
               if (!col_end) begin
                  col_d = col_q + ADR_W'(1);
               end else begin
                  col_d = '0;
                  if (!row_end) begin
                     row_d = row_q + ADR_W'(1);
                  end else begin
                     row_d = '0;
                     if (!grp_end) begin
                        base_d = base_q + ADR_W'(CORE_COUNT);
                     end else begin
                        base_d  = '0;
                        state_d = ST_DRAIN;
                     end
                  end
               end
            end
         end
         ST_DRAIN: begin
            if (wb_vld_q == '0) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            // A held start keeps us here so one request never runs twice.
            if (!start) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // --------------------------------------------------- write-back pipe
   // Free-running shift register: it advances regardless of in_ready.
   always_ff @(posedge CLOCK_25 or posedge rst) begin
      if (rst) begin
         wb_vld_q <= '0;
         for (int i = 0; i < PIPE_DEPTH; i++) begin
            wb_row_q[i]  <= '0;
            wb_base_q[i] <= '0;
         end
      end else begin
         wb_vld_q <= wb_vld_d;
         for (int i = 0; i < PIPE_DEPTH; i++) begin
            wb_row_q[i]  <= wb_row_d[i];
            wb_base_q[i] <= wb_base_d[i];
         end
      end
   end

   always_comb begin
      wb_vld_d     = '0;
      wb_vld_d[0]  = accept & col_end;
      wb_row_d[0]  = row_q;
      wb_base_d[0] = base_q;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
         wb_vld_d[i]  = wb_vld_q[i-1];
         wb_row_d[i]  = wb_row_q[i-1];
         wb_base_d[i] = wb_base_q[i-1];
      end
   end

   // ------------------------------------------------------------ outputs
   genvar gi;
   generate
      for (gi = 0; gi < CORE_COUNT; gi++) begin : g_mask
         assign o_core_mask[gi] = ((base_ext + EXT_W'(gi)) < scol_ext);
      end
   endgenerate

   assign o_valid        = run;
   assign o_column_adr   = col_q;
   assign o_row_adr      = row_q;
   assign o_core_base    = base_q;
   // Gated with run so idle/reset state shows no spurious first/last beat.
   assign o_acc_clr      = run & (col_q == '0);
   assign o_last         = run & col_end;
   assign o_wb_valid     = wb_vld_q[PIPE_DEPTH-1];
   assign o_wb_row       = wb_row_q[PIPE_DEPTH-1];
   assign o_wb_core_base = wb_base_q[PIPE_DEPTH-1];
   assign o_busy         = (state_q == ST_LOAD) || run || (state_q == ST_DRAIN);
   assign o_done         = (state_q == ST_DONE);
   assign o_err          = err_q;
   assign o_state        = state_q;

`ifdef MATRIX_SEQ_PERF_EN
   logic [31:0] busy_cnt_q, busy_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_ff @(posedge CLOCK_25 or posedge rst) begin
      if (rst) begin
         busy_cnt_q  <= '0;
         stall_cnt_q <= '0;
      end else begin
         busy_cnt_q  <= busy_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   always_comb begin
      busy_cnt_d  = busy_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if ((state_q == ST_IDLE) && (state_d == ST_LOAD)) begin
         busy_cnt_d  = '0;
         stall_cnt_d = '0;
      end else begin
         if (o_busy && (busy_cnt_q != '1)) begin
            busy_cnt_d = busy_cnt_q + 32'd1;
         end
         if (run && !in_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
         end
      end
   end

   assign o_busy_cycles  = busy_cnt_q;
   assign o_stall_cycles = stall_cnt_q;
`else
   assign o_busy_cycles  = 32'd0;
   assign o_stall_cycles = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_matrix_tile_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_matrix_tile_sequencer
// Purpose  : Self-checking bench for matrix_tile_sequencer. A job-level model
//            expands each request into its expected beat list and write-back
//            schedule and checks the DUT cycle by cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_tile_sequencer;
   localparam int CORE_COUNT = 4;
   localparam int ADR_W      = 5;
   localparam int SIZE_W     = 8;
   localparam int PIPE_DEPTH = 2;

   logic                  CLOCK_25 = 1'b0;
   logic                  rst;
   logic                  start;
   logic [SIZE_W-1:0]     size_column;
   logic [SIZE_W-1:0]     size_row;
   logic                  in_ready;
   logic                  o_valid;
   logic [ADR_W-1:0]      o_column_adr;
   logic [ADR_W-1:0]      o_row_adr;
   logic [ADR_W-1:0]      o_core_base;
   logic [CORE_COUNT-1:0] o_core_mask;
   logic                  o_acc_clr;
   logic                  o_last;
   logic                  o_wb_valid;
   logic [ADR_W-1:0]      o_wb_row;
   logic [ADR_W-1:0]      o_wb_core_base;
   logic                  o_busy;
   logic                  o_done;
   logic                  o_err;
   logic [2:0]            o_state;
   logic [31:0]           o_busy_cycles;
   logic [31:0]           o_stall_cycles;

   matrix_tile_sequencer #(
      .CORE_COUNT (CORE_COUNT),
      .ADR_W      (ADR_W),
      .SIZE_W     (SIZE_W),
      .PIPE_DEPTH (PIPE_DEPTH)
   ) dut (
      .CLOCK_25       (CLOCK_25),
      .rst            (rst),
      .start          (start),
      .size_column    (size_column),
      .size_row       (size_row),
      .in_ready       (in_ready),
      .o_valid        (o_valid),
      .o_column_adr   (o_column_adr),
      .o_row_adr      (o_row_adr),
      .o_core_base    (o_core_base),
      .o_core_mask    (o_core_mask),
      .o_acc_clr      (o_acc_clr),
      .o_last         (o_last),
      .o_wb_valid     (o_wb_valid),
      .o_wb_row       (o_wb_row),
      .o_wb_core_base (o_wb_core_base),
      .o_busy         (o_busy),
      .o_done         (o_done),
      .o_err          (o_err),
      .o_state        (o_state),
      .o_busy_cycles  (o_busy_cycles),
      .o_stall_cycles (o_stall_cycles)
   );

   always #5 CLOCK_25 = ~CLOCK_25;

   typedef struct {
      int col;
      int row;
      int base;
      int mask;
      bit clr;
      bit last;
   } beat_t;

   typedef struct {
      int cyc;
      int row;
      int base;
   } wb_t;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_valid"},   32'(o_valid), 0);
      check({tag, "_col"},     32'(o_column_adr), 0);
      check({tag, "_row"},     32'(o_row_adr), 0);
      check({tag, "_base"},    32'(o_core_base), 0);
      check({tag, "_mask"},    32'(o_core_mask), 0);
      check({tag, "_clr"},     32'(o_acc_clr), 0);
      check({tag, "_last"},    32'(o_last), 0);
      check({tag, "_wbv"},     32'(o_wb_valid), 0);
      check({tag, "_wbrow"},   32'(o_wb_row), 0);
      check({tag, "_wbbase"},  32'(o_wb_core_base), 0);
      check({tag, "_busy"},    32'(o_busy), 0);
      check({tag, "_done"},    32'(o_done), 0);
      check({tag, "_err"},     32'(o_err), 0);
      check({tag, "_state"},   32'(o_state), 0);
      check({tag, "_bcyc"},    o_busy_cycles, 0);
      check({tag, "_scyc"},    o_stall_cycles, 0);
   endtask

   // Runs one job from a negedge with the DUT in IDLE. mode: 0 = in_ready
   // always 1, 1 = repeating 1,0,0,1 pattern, 2 = random.
   task automatic run_job(input int sc, input int sr, input int mode, input bit hold);
      beat_t beat_q[$];
      wb_t   wb_q[$];
      beat_t bt;
      wb_t   w;
      int    k, last_wb, stalls, nbeats, wb_exp_cnt, wb_seen, budget, m;
      bit    reject, exp_valid, exp_wb, exp_done, finished;

      reject = (sc == 0) || (sr == 0) || (sc > (1 << ADR_W)) || (sr > (1 << ADR_W));
      if (!reject) begin
         for (int b = 0; b < sc; b += CORE_COUNT)
            for (int r = 0; r < sr; r++)
               for (int c = 0; c < sc; c++) begin
                  m = 0;
                  for (int i = 0; i < CORE_COUNT; i++)
                     if (b + i < sc) m |= (1 << i);
                  bt.col = c; bt.row = r; bt.base = b; bt.mask = m;
                  bt.clr = (c == 0); bt.last = (c == sc - 1);
                  beat_q.push_back(bt);
               end
      end
      nbeats     = beat_q.size();
      wb_exp_cnt = reject ? 0 : ((sc + CORE_COUNT - 1) / CORE_COUNT) * sr;
      budget     = 8 * nbeats + 50;
      k = 0; last_wb = -10; stalls = 0; wb_seen = 0; finished = 0;

      size_column = SIZE_W'(sc);
      size_row    = SIZE_W'(sr);
      start       = 1'b1;
      while (!finished) begin
         @(negedge CLOCK_25);
         k++;
         if (k == 1) begin
            if (!hold) start = 1'b0;
            // Sizes are already latched; scrambling them must have no effect.
            size_column = SIZE_W'($urandom);
            size_row    = SIZE_W'($urandom);
         end
         case (mode)
            0: in_ready = 1'b1;
            1: in_ready = ((k % 4) == 0) || ((k % 4) == 3);
            default: in_ready = 1'($urandom_range(0, 1));
         endcase

         exp_valid = !reject && (k >= 2) && (beat_q.size() > 0);
         check("valid", 32'(o_valid), 32'(exp_valid));
         if (exp_valid) begin
            bt = beat_q[0];
            check("col",  32'(o_column_adr), bt.col);
            check("row",  32'(o_row_adr),    bt.row);
            check("base", 32'(o_core_base),  bt.base);
            check("mask", 32'(o_core_mask),  bt.mask);
            check("clr",  32'(o_acc_clr),    32'(bt.clr));
            check("last", 32'(o_last),       32'(bt.last));
            if (in_ready) begin
               void'(beat_q.pop_front());
               if (bt.last) begin
                  w.cyc = k + PIPE_DEPTH; w.row = bt.row; w.base = bt.base;
                  wb_q.push_back(w);
               end
            end else begin
               stalls++;
            end
         end

         exp_wb = (wb_q.size() > 0) && (wb_q[0].cyc == k);
         check("wb_valid", 32'(o_wb_valid), 32'(exp_wb));
         if (exp_wb) begin
            check("wb_row",  32'(o_wb_row),       wb_q[0].row);
            check("wb_base", 32'(o_wb_core_base), wb_q[0].base);
            void'(wb_q.pop_front());
            last_wb = k;
         end
         if (o_wb_valid) wb_seen++;

         exp_done = reject ? (k >= 2)
                           : ((beat_q.size() == 0) && (wb_q.size() == 0) && (k == last_wb + 2));
         check("done", 32'(o_done), 32'(exp_done));
         check("busy", 32'(o_busy), 32'((k >= 1) && !exp_done));
         if (exp_done) begin
            finished = 1;
         end else if (k > budget) begin
            check("done_timeout", 32'(o_done), 1);
            finished = 1;
         end
      end

      check("err",      32'(o_err), 32'(reject));
      check("wb_count", wb_seen, wb_exp_cnt);
      check("state_done", 32'(o_state), 4);
`ifdef MATRIX_SEQ_PERF_EN
      check("busy_cycles",  o_busy_cycles,  reject ? 1 : (1 + nbeats + stalls + PIPE_DEPTH + 1));
      check("stall_cycles", o_stall_cycles, stalls);
`else
      check("busy_cycles",  o_busy_cycles,  0);
      check("stall_cycles", o_stall_cycles, 0);
`endif
      if (hold) begin
         repeat (3) begin
            @(negedge CLOCK_25);
            check("hold_done",  32'(o_done),  1);
            check("hold_valid", 32'(o_valid), 0);
         end
         start = 1'b0;
      end
      @(negedge CLOCK_25);
      check("back_idle", 32'(o_state), 0);
   endtask

   initial begin
      rst         = 1'b1;
      start       = 1'b0;
      size_column = '0;
      size_row    = '0;
      in_ready    = 1'b0;
      #2;
      check_zero("reset");
      @(negedge CLOCK_25);
      @(negedge CLOCK_25);
      rst = 1'b0;
      @(negedge CLOCK_25);

      run_job(8, 8, 0, 0);     // full groups
      run_job(6, 2, 0, 0);     // partial final group
      run_job(6, 2, 1, 0);     // back-pressure 1,0,0,1
      run_job(8, 0, 0, 0);     // rejected: zero rows
      run_job(33, 4, 0, 0);    // rejected: column count beyond address range
      run_job(32, 1, 2, 0);    // largest legal column count
      run_job(1, 3, 2, 0);     // single-beat dot products

      // Reset in the middle of a job with a write-back in flight.
      size_column = SIZE_W'(8);
      size_row    = SIZE_W'(8);
      in_ready    = 1'b1;
      start       = 1'b1;
      @(negedge CLOCK_25);
      start = 1'b0;
      repeat (10) @(negedge CLOCK_25);
      #2 rst = 1'b1;
      #1 check_zero("midrst");
      @(negedge CLOCK_25);
      @(negedge CLOCK_25);
      rst = 1'b0;
      repeat (6) begin
         @(negedge CLOCK_25);
         check("post_rst_wbv",   32'(o_wb_valid), 0);
         check("post_rst_state", 32'(o_state), 0);
      end

      run_job(5, 3, 0, 1);     // start held through DONE
      run_job(3, 2, 2, 0);     // raising start again begins a fresh job

      for (int j = 0; j < 4; j++) begin
         run_job(int'($urandom_range(1, 20)), int'($urandom_range(1, 4)),
                 int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
